// File: rtl/seq_pkg.sv
// Shared encodings for the serial sequence path: serializer and detector.
package seq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } seq_state_t;

    localparam int   DEFAULT_WIDTH    = 8;
    localparam logic DEFAULT_IDLE_BIT = 1'b1;

    function automatic int cnt_w(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

    localparam int DEFAULT_CNT_W = cnt_w(DEFAULT_WIDTH);

endpackage

// File: rtl/seq_word_serializer.sv
// Parallel-to-serial feeder: valid/ready word in, one registered bit per clock out.
module seq_word_serializer
    import seq_pkg::*;
#(
    parameter int   WIDTH     = DEFAULT_WIDTH,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = DEFAULT_IDLE_BIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             ser_out,
    output logic             ser_active,
    output logic             word_done
);

    localparam int             CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    seq_state_t       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] nxt;
    logic             take;

    assign data_ready = !rst && (state == IDLE || cnt == LAST);
    assign take       = data_valid && data_ready;

    // Rotate so the next bit to send always sits at the output end.
    assign nxt = MSB_FIRST ? {sreg[WIDTH-2:0], sreg[WIDTH-1]}
                           : {sreg[0], sreg[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            ser_out    <= IDLE_BIT;
            ser_active <= 1'b0;
            word_done  <= 1'b0;
        end else if (take) begin
            state      <= SHIFT;
            sreg       <= data_in;
            cnt        <= '0;
            ser_out    <= MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
            ser_active <= 1'b1;
            word_done  <= 1'b0;
        end else if (state == SHIFT && cnt != LAST) begin
            sreg       <= nxt;
            cnt        <= cnt + 1'b1;
            ser_out    <= MSB_FIRST ? nxt[WIDTH-1] : nxt[0];
            word_done  <= (cnt + 1'b1) == LAST;
        end else begin
            state      <= IDLE;
            cnt        <= '0;
            ser_out    <= IDLE_BIT;
            ser_active <= 1'b0;
            word_done  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_word_serializer.sv
// Directed bench for seq_word_serializer, MSB-first and LSB-first instances.
module tb_seq_word_serializer;

    logic       clk;
    logic       rst;
    logic [7:0] d_m, d_l;
    logic       v_m, v_l;
    logic       rdy_m, rdy_l;
    logic       so_m, so_l;
    logic       act_m, act_l;
    logic       done_m, done_l;

    int passed;
    int total;

    seq_word_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut (
        .clk(clk), .rst(rst), .data_in(d_m), .data_valid(v_m),
        .data_ready(rdy_m), .ser_out(so_m), .ser_active(act_m),
        .word_done(done_m)
    );

    seq_word_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_l (
        .clk(clk), .rst(rst), .data_in(d_l), .data_valid(v_l),
        .data_ready(rdy_l), .ser_out(so_l), .ser_active(act_l),
        .word_done(done_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rst = 1'b1;
        v_m = 1'b0; v_l = 1'b0;
        d_m = '0;   d_l = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({so_m, act_m, done_m, rdy_m} !== 4'b1000)
            $display("FAIL reset_state: got so/act/done/rdy=%b want 1000",
                     {so_m, act_m, done_m, rdy_m});
        else passed++;
        rst = 1'b0;
        #1;
        total++;
        if (rdy_m !== 1'b1)
            $display("FAIL reset_release_ready: got %b want 1", rdy_m);
        else passed++;
    endtask

    task automatic test_idle_level;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            total++;
            if ({so_m, act_m, done_m, rdy_m} !== 4'b1001)
                $display("FAIL idle_level c%0d: got so/act/done/rdy=%b want 1001",
                         c, {so_m, act_m, done_m, rdy_m});
            else passed++;
        end
    endtask

    task automatic test_single_msb;
        logic [7:0] seq;
        seq = 8'b0110_0000;
        d_m = 8'b0110_0000;
        v_m = 1'b1;
        @(posedge clk);
        #1;
        v_m = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            total++;
            if ({so_m, act_m, done_m} !== {seq[7-i], 1'b1, i == 7})
                $display("FAIL single_msb bit%0d: got so/act/done=%b want %b",
                         i, {so_m, act_m, done_m}, {seq[7-i], 1'b1, i == 7});
            else passed++;
        end
        @(posedge clk);
        #1;
        total++;
        if ({so_m, act_m, done_m, rdy_m} !== 4'b1001)
            $display("FAIL single_msb_after: got %b want 1001",
                     {so_m, act_m, done_m, rdy_m});
        else passed++;
    endtask

    task automatic test_back_to_back;
        logic [15:0] seq;
        seq = 16'hA53C;
        d_m = 8'hA5;
        v_m = 1'b1;
        @(posedge clk);
        #1;
        d_m = 8'h3C;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            if (i == 8) v_m = 1'b0;
            total++;
            if ({so_m, act_m, done_m} !==
                {seq[15-i], 1'b1, (i == 7 || i == 15)})
                $display("FAIL b2b bit%0d: got so/act/done=%b want %b",
                         i, {so_m, act_m, done_m},
                         {seq[15-i], 1'b1, (i == 7 || i == 15)});
            else passed++;
            if (i == 7) begin
                total++;
                if (rdy_m !== 1'b1)
                    $display("FAIL b2b_ready: got %b want 1", rdy_m);
                else passed++;
            end
        end
        @(posedge clk);
        #1;
        total++;
        if ({so_m, act_m} !== 2'b10)
            $display("FAIL b2b_after: got so/act=%b want 10", {so_m, act_m});
        else passed++;
    endtask

    task automatic test_lsb_first;
        logic [7:0] seq;
        seq = 8'b0110_0000;
        d_l = 8'b0000_0110;
        v_l = 1'b1;
        @(posedge clk);
        #1;
        v_l = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            total++;
            if ({so_l, act_l, done_l} !== {seq[7-i], 1'b1, i == 7})
                $display("FAIL lsb_first bit%0d: got so/act/done=%b want %b",
                         i, {so_l, act_l, done_l}, {seq[7-i], 1'b1, i == 7});
            else passed++;
        end
        @(posedge clk);
        #1;
        total++;
        if ({so_l, act_l} !== 2'b10)
            $display("FAIL lsb_after: got so/act=%b want 10", {so_l, act_l});
        else passed++;
    endtask

    task automatic test_busy_hold;
        logic [7:0] seq;
        seq = 8'h5A;
        d_m = 8'h81;
        v_m = 1'b1;
        @(posedge clk);
        #1;
        v_m = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            if (i == 2) begin
                d_m = 8'h5A;
                v_m = 1'b1;
            end
            if (i >= 2) begin
                total++;
                if (rdy_m !== (i == 7))
                    $display("FAIL busy_ready bit%0d: got %b want %b",
                             i, rdy_m, (i == 7));
                else passed++;
            end
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) v_m = 1'b0;
            total++;
            if ({so_m, act_m} !== {seq[7-i], 1'b1})
                $display("FAIL busy_word bit%0d: got so/act=%b want %b",
                         i, {so_m, act_m}, {seq[7-i], 1'b1});
            else passed++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_word;
        d_m = 8'hFF;
        v_m = 1'b1;
        @(posedge clk);
        #1;
        v_m = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        d_m = 8'h00;
        v_m = 1'b1;
        #1;
        total++;
        if (rdy_m !== 1'b0)
            $display("FAIL rst_mid_ready: got %b want 0", rdy_m);
        else passed++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        v_m = 1'b0;
        #1;
        total++;
        if ({so_m, act_m, done_m, rdy_m} !== 4'b1001)
            $display("FAIL rst_mid_after: got so/act/done/rdy=%b want 1001",
                     {so_m, act_m, done_m, rdy_m});
        else passed++;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            total++;
            if ({act_m, done_m} !== 2'b00)
                $display("FAIL rst_mid_quiet c%0d: got act/done=%b want 00",
                         c, {act_m, done_m});
            else passed++;
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_idle_level();
        test_single_msb();
        test_back_to_back();
        test_lsb_first();
        test_busy_hold();
        test_reset_mid_word();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
